// File: rtl/spatial_filter_stream_pkg.sv
// Shared constants for the 3x3 streaming spatial filter: kernel select encodings,
// Gaussian weights and the headroom added to the pixel width for signed arithmetic.
package spatial_filter_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GAUSS = 2'd1,
        MODE_SOBEL = 2'd2,
        MODE_LAPL  = 2'd3
    } mode_e;

    localparam int G_CORNER = 1;
    localparam int G_EDGE   = 2;
    localparam int G_CENTRE = 4;
    localparam int G_SHIFT  = 4;

    // Worst case is the Gaussian sum of 16 pixels: 4 extra bits plus a sign bit
    localparam int INT_EXT  = 5;

endpackage

// File: rtl/spatial_filter_stream_if.sv
// Pixel stream bundle: slave-side input stream and master-side filtered output stream.
interface spatial_filter_stream_if #(
    parameter int PIXEL_SIZE = 8
);
    logic                  i_s_data_valid;
    logic [PIXEL_SIZE-1:0] i_s_data;
    logic                  o_s_ready;
    logic                  o_m_data_valid;
    logic [PIXEL_SIZE-1:0] o_m_data;
    logic                  o_m_last;
    logic                  i_m_ready;

    // Filter side
    modport slave (
        input  i_s_data_valid, i_s_data, i_m_ready,
        output o_s_ready, o_m_data_valid, o_m_data, o_m_last
    );

    // Source/sink side
    modport master (
        output i_s_data_valid, i_s_data, i_m_ready,
        input  o_s_ready, o_m_data_valid, o_m_data, o_m_last
    );
endinterface

// File: rtl/spatial_filter_stream_sf_line_window.sv
// Raster position tracking, two line memories and the 3x3 window; flags each
// accepted pixel that completes an interior window.
module sf_line_window #(
    parameter int PIXEL_SIZE   = 8,
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            s_valid,
    input  logic [PIXEL_SIZE-1:0]           s_data,
    output logic [2:0][2:0][PIXEL_SIZE-1:0] win,
    output logic                            win_valid,
    output logic                            win_last,
    output logic                            frame_start
);
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [PIXEL_SIZE-1:0] line0 [IMAGE_WIDTH];
    logic [PIXEL_SIZE-1:0] line1 [IMAGE_WIDTH];
    logic                  accept, col_last, row_last;

    assign accept      = s_valid && en;
    assign col_last    = (col == CW'(IMAGE_WIDTH - 1));
    assign row_last    = (row == RW'(IMAGE_HEIGHT - 1));
    assign frame_start = accept && (col == '0) && (row == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (en) begin
            win_valid <= accept && (row >= RW'(2)) && (col >= CW'(2));
            win_last  <= accept && row_last && col_last;
            if (accept) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col_last)
                    row <= row_last ? '0 : row + 1'b1;
            end
        end
    end

    // line0 holds the previous row, line1 the one before; no reset needed since
    // every row is rewritten before a window reads it
    always_ff @(posedge clk) begin
        if (accept) begin
            line0[col] <= s_data;
            line1[col] <= line0[col];
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= line1[col];
            win[1][2] <= line0[col];
            win[2][2] <= s_data;
        end
    end

endmodule

// File: rtl/spatial_filter_stream.sv
// 3x3 streaming spatial filter: window generation feeds a two-stage kernel
// datapath (partial sums, then reduce/saturate) behind a stallable output register.
module spatial_filter_stream
    import spatial_filter_pkg::*;
#(
    parameter int PIXEL_SIZE   = 8,
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512
) (
    input  logic                    axis_clk,
    input  logic                    axis_reset_n,
    input  logic [1:0]              i_mode,
    spatial_filter_stream_if.slave  bus,
    output logic                    o_intr
);
    localparam int IW     = PIXEL_SIZE + INT_EXT;
    localparam int STAGES = 2;

    typedef logic signed [IW-1:0] acc_t;

    localparam acc_t PIX_MAX = acc_t'((1 << PIXEL_SIZE) - 1);

    function automatic acc_t px(input logic [PIXEL_SIZE-1:0] v);
        return acc_t'({{INT_EXT{1'b0}}, v});
    endfunction

    function automatic acc_t abs_v(input acc_t v);
        return (v < 0) ? -v : v;
    endfunction

    logic [2:0][2:0][PIXEL_SIZE-1:0] win;
    logic                  win_valid, win_last, frame_start, en;
    logic [STAGES:1]       vld_pipe;
    logic                  last_s1;
    mode_e                 mode_q, mode_s1;
    acc_t                  p [3][3];
    acc_t                  s1_a, s1_b, a_s1, b_s1, s2_sum;
    logic [PIXEL_SIZE-1:0] s2_data;

    assign en                 = !bus.o_m_data_valid || bus.i_m_ready;
    assign bus.o_s_ready      = en;
    assign bus.o_m_data_valid = vld_pipe[STAGES];
    assign o_intr             = bus.o_m_data_valid && bus.i_m_ready && bus.o_m_last;

    sf_line_window #(
        .PIXEL_SIZE  (PIXEL_SIZE),
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT)
    ) u_win (
        .clk        (axis_clk),
        .rst_n      (axis_reset_n),
        .en         (en),
        .s_valid    (bus.i_s_data_valid),
        .s_data     (bus.i_s_data),
        .win        (win),
        .win_valid  (win_valid),
        .win_last   (win_last),
        .frame_start(frame_start)
    );

    // Stage 1: p[row][col], row 0 is the oldest line, col 0 the leftmost pixel
    always_comb begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = px(win[i][j]);
        s1_a = '0;
        s1_b = '0;
        case (mode_q)
            MODE_PASS:  s1_a = p[1][1];
            MODE_GAUSS: begin
                s1_a = acc_t'(G_CORNER) * (p[0][0] + p[0][2]) + acc_t'(G_EDGE) * (p[0][1] + p[1][0]);
                s1_b = acc_t'(G_CENTRE) * p[1][1] + acc_t'(G_EDGE) * (p[1][2] + p[2][1])
                     + acc_t'(G_CORNER) * (p[2][0] + p[2][2]);
            end
            MODE_SOBEL: begin
                s1_a = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
                s1_b = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
            end
            default:    s1_a = (p[1][1] <<< 2) - p[0][1] - p[2][1] - p[1][0] - p[1][2];
        endcase
    end

    // Stage 2: Laplacian leaves s1_b at zero, so it shares the Sobel magnitude path
    always_comb begin
        s2_sum  = '0;
        s2_data = '0;
        case (mode_s1)
            MODE_PASS:  s2_data = a_s1[PIXEL_SIZE-1:0];
            MODE_GAUSS: begin
                s2_sum  = (a_s1 + b_s1) >>> G_SHIFT;
                s2_data = s2_sum[PIXEL_SIZE-1:0];
            end
            default: begin
                s2_sum  = abs_v(a_s1) + abs_v(b_s1);
                s2_data = (s2_sum > PIX_MAX) ? '1 : s2_sum[PIXEL_SIZE-1:0];
            end
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_reset_n) begin
            mode_q       <= MODE_PASS;
            mode_s1      <= MODE_PASS;
            vld_pipe     <= '0;
            last_s1      <= 1'b0;
            bus.o_m_data <= '0;
            bus.o_m_last <= 1'b0;
        end else if (en) begin
            if (frame_start)
                mode_q <= mode_e'(i_mode);
            mode_s1      <= mode_q;
            vld_pipe     <= {vld_pipe[STAGES-1:1], win_valid};
            last_s1      <= win_last;
            bus.o_m_data <= s2_data;
            bus.o_m_last <= last_s1;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (en) begin
            a_s1 <= s1_a;
            b_s1 <= s1_b;
        end
    end

endmodule

// File: tb/tb_spatial_filter_stream.sv
// Directed/randomized frames against a kernel-level reference model of the
// 3x3 filter (8-bit pixels, 8x6 frames).
module tb_spatial_filter_stream;
    localparam int P    = 8;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NOUT = (W - 2) * (H - 2);

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   mode;
    logic         intr;
    int           tests = 0;
    int           fails = 0;
    int           img [H][W];

    spatial_filter_stream_if #(.PIXEL_SIZE(P)) bus ();

    spatial_filter_stream #(
        .PIXEL_SIZE  (P),
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H)
    ) dut (
        .axis_clk    (clk),
        .axis_reset_n(rst_n),
        .i_mode      (mode),
        .bus         (bus),
        .o_intr      (intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 255) ? 255 : a;
    endfunction

    // Kernel applied around centre (r,c) straight from the weight definitions
    function automatic int ref_pix(input int m, input int r, input int c);
        int acc, gx, gy, wr, wc;
        acc = 0; gx = 0; gy = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                wr = (dr == 0) ? 2 : 1;
                wc = (dc == 0) ? 2 : 1;
                acc += wr * wc * img[r+dr][c+dc];
                gx  += dc * wr * img[r+dr][c+dc];
                gy  += dr * wc * img[r+dr][c+dc];
            end
        case (m)
            0:       return img[r][c];
            1:       return acc / 16;
            2:       return sat((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy));
            default: return sat(4 * img[r][c] - img[r-1][c] - img[r+1][c] - img[r][c-1] - img[r][c+1]);
        endcase
    endfunction

    task automatic fill_img(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = (c < 4) ? 0 : 255;
                    2:       img[r][c] = (r * W + c) * 5;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
    endtask

    // ready_mode: 0 always ready, 3 ready one cycle in three, other values random
    task automatic run_frame(input string tag, input int mode_a, input int mode_b,
                             input int switch_idx, input int ready_mode, input bit bubbles);
        int          exp_q[$];
        int          pix, got, cyc, eff_mode, extra;
        bit          prev_stall;
        logic [P-1:0] prev_data;
        logic        prev_last;
        eff_mode = (switch_idx > 0) ? mode_a : mode_b;
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++)
                exp_q.push_back(ref_pix(eff_mode, r, c));
        pix = 0; got = 0; cyc = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
        while (got < NOUT && cyc < 3000) begin
            @(negedge clk);
            case (ready_mode)
                0:       bus.i_m_ready = 1'b1;
                3:       bus.i_m_ready = ((cyc % 3) == 2);
                default: bus.i_m_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (pix < W * H && (!bubbles || $urandom_range(0, 3) != 0)) begin
                bus.i_s_data_valid = 1'b1;
                bus.i_s_data       = P'(img[pix / W][pix % W]);
                mode               = 2'((pix < switch_idx) ? mode_a : mode_b);
            end else begin
                bus.i_s_data_valid = 1'b0;
            end
            #1;
            check({tag, " s_ready"}, bus.o_s_ready, !bus.o_m_data_valid || bus.i_m_ready);
            if (prev_stall) begin
                check({tag, " stall valid"}, bus.o_m_data_valid, 1);
                check({tag, " stall data"}, bus.o_m_data, prev_data);
                check({tag, " stall last"}, bus.o_m_last, prev_last);
            end
            if (bus.o_m_data_valid && bus.i_m_ready) begin
                check({tag, " data"}, bus.o_m_data, exp_q[got]);
                check({tag, " last"}, bus.o_m_last, (got == NOUT - 1));
                check({tag, " intr"}, intr, (got == NOUT - 1));
                got++;
            end else begin
                check({tag, " intr idle"}, intr, 0);
            end
            prev_stall = bus.o_m_data_valid && !bus.i_m_ready;
            prev_data  = bus.o_m_data;
            prev_last  = bus.o_m_last;
            if (bus.i_s_data_valid && bus.o_s_ready)
                pix++;
            cyc++;
        end
        check({tag, " outputs received"}, got, NOUT);
        check({tag, " pixels accepted"}, pix, W * H);
        extra = 0;
        bus.i_s_data_valid = 1'b0;
        bus.i_m_ready      = 1'b1;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (bus.o_m_data_valid) extra++;
        end
        check({tag, " extra outputs"}, extra, 0);
    endtask

    initial begin
        rst_n              = 1'b0;
        mode               = 2'd0;
        bus.i_s_data_valid = 1'b0;
        bus.i_s_data       = '0;
        bus.i_m_ready      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid", bus.o_m_data_valid, 0);
        check("reset data", bus.o_m_data, 0);
        check("reset last", bus.o_m_last, 0);
        check("reset intr", intr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        fill_img(0);
        run_frame("const gauss", 1, 1, 0, 0, 0);
        run_frame("const sobel", 2, 2, 0, 0, 0);
        run_frame("const lapl", 3, 3, 0, 0, 0);

        fill_img(1);
        run_frame("step sobel", 2, 2, 0, 0, 0);

        fill_img(2);
        run_frame("ramp pass", 0, 0, 0, 0, 0);
        run_frame("ramp pass stalled", 0, 0, 0, 3, 0);

        for (int m = 0; m < 4; m++) begin
            fill_img(3);
            run_frame("random", m, m, 0, 1, 1);
        end

        // Mode changes to Sobel at pixel (3,3); the frame keeps the Gaussian it started with
        fill_img(3);
        run_frame("switch gauss", 1, 2, 3 * W + 3, 0, 0);
        fill_img(3);
        run_frame("switch sobel", 2, 2, 0, 0, 0);

        // Partial frame up to pixel (2,4), reset at (2,5), then a clean frame
        fill_img(3);
        for (int i = 0; i < 2 * W + 5; i++) begin
            @(negedge clk);
            bus.i_m_ready      = 1'b1;
            bus.i_s_data_valid = 1'b1;
            bus.i_s_data       = P'(img[i / W][i % W]);
            mode               = 2'd1;
        end
        @(negedge clk);
        bus.i_s_data_valid = 1'b0;
        rst_n              = 1'b0;
        @(posedge clk);
        #1;
        check("midreset valid", bus.o_m_data_valid, 0);
        check("midreset data", bus.o_m_data, 0);
        check("midreset last", bus.o_m_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_img(3);
        run_frame("after reset lapl", 3, 3, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
